// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 21;
  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/instr_fetch_unit_pc_gen.sv
// Program counter for the fetch stage: sequential +4 advance, redirect load, word alignment.
module instr_fetch_unit_pc_gen
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] target_pc,
  output logic [ADDR_W-1:0] pc
);

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(INSTR_BYTES - 1);
  endfunction

  // A redirect takes priority over the sequential advance; the add wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= align(RESET_PC);
    end else if (load) begin
      pc <= align(target_pc);
    end else if (advance) begin
      pc <= pc + ADDR_W'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch stage: one outstanding imem request, instruction buffer to decode, redirect squash.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [10:0]        dec_opcode,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  fetch_state_t       state_q;
  logic               kill_q;
  logic               dec_valid_q;
  logic [INSTR_W-1:0] dec_instr_q;
  logic [ADDR_W-1:0]  dec_pc_q;
  logic [ADDR_W-1:0]  pc;
  logic               hold_handshake;

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc;
  assign hold_handshake = (state_q == HOLD) && dec_ready;

  instr_fetch_unit_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (redirect_valid),
    .advance   (hold_handshake),
    .target_pc (redirect_pc),
    .pc        (pc)
  );

  // kill marks an in-flight request whose response belongs to a squashed path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REQ;
      kill_q      <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_instr_q <= '0;
      dec_pc_q    <= '0;
    end else begin
      unique case (state_q)
        REQ: begin
          if (imem_req_ready) begin
            state_q <= WAIT;
            kill_q  <= redirect_valid;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (kill_q || redirect_valid) begin
              kill_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              dec_instr_q <= imem_rsp_data;
              dec_pc_q    <= pc;
              dec_valid_q <= 1'b1;
              state_q     <= HOLD;
            end
          end else if (redirect_valid) begin
            kill_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || dec_ready) begin
            dec_valid_q <= 1'b0;
            state_q     <= REQ;
          end
        end
        default: begin
          state_q     <= REQ;
          kill_q      <= 1'b0;
          dec_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign dec_valid  = dec_valid_q;
  assign dec_instr  = dec_instr_q;
  assign dec_pc     = dec_pc_q;
  assign dec_opcode = dec_instr_q[OPCODE_MSB:OPCODE_LSB];

endmodule
